lfsr_period_meter: RTL and testbench

- Control and observation stage wrapped around the team's 6-bit Galois LFSR.
- Drives the LFSR's load/shift select and parallel load value, and monitors its parallel state output.
- On a start request it seeds the LFSR, then lets it free-run. It measures the number of shifts until the seed state recurs, which is the cycle period for that seed.
- Flags the all-zero lock-up seed and runaway sequences via a timeout.

---
 rtl/lfsr_period_meter.sv | 128 ++++++++++++
 tb/tb_lfsr_period_meter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/lfsr_period_meter.sv
// rtl/lfsr_period_meter.sv - seeds a Galois LFSR and measures its cycle period for that seed
// Optional LFSR_PERIOD_LOAD_CHK_EN adds load_err: the loaded state is verified on the first RUN cycle.
module lfsr_period_meter #(
    parameter int WIDTH      = 6,
    parameter int MAX_CYCLES = 64,
    parameter int CNT_W      = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] seed,
    input  logic [WIDTH-1:0] lfsr_q,
    output logic             lfsr_sel,
    output logic [WIDTH-1:0] lfsr_load_val,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] period,
    output logic             lockup,
`ifdef LFSR_PERIOD_LOAD_CHK_EN
    output logic             load_err,
`endif
    output logic             timeout
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_CYCLES);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] seed_reg;
    logic [CNT_W-1:0] cnt;
    logic             accept, accept_zero, match, tmo, ld_fail;

    always_comb begin
        state_d     = state_q;
        accept      = 1'b0;
        accept_zero = 1'b0;
        match       = 1'b0;
        tmo         = 1'b0;
        ld_fail     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (seed != '0) begin
                        accept  = 1'b1;
                        state_d = LOAD;
                    end else begin
                        accept_zero = 1'b1;
                        state_d     = DONE;
                    end
                end
            end
            LOAD: state_d = RUN;
            RUN: begin
`ifdef LFSR_PERIOD_LOAD_CHK_EN
                ld_fail = (cnt == '0) && (lfsr_q != seed_reg);
`endif
                if (ld_fail) begin
                    state_d = DONE;
                end else if (cnt != '0 && lfsr_q == seed_reg) begin
                    match   = 1'b1;
                    state_d = DONE;
                end else if (cnt == MAX_CNT) begin
                    tmo     = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers; a recurrence outranks timeout because match is decoded first above.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seed_reg <= '0;
            cnt      <= '0;
            period   <= '0;
            lockup   <= 1'b0;
            timeout  <= 1'b0;
`ifdef LFSR_PERIOD_LOAD_CHK_EN
            load_err <= 1'b0;
`endif
        end else begin
            if (accept || accept_zero) begin
                seed_reg <= seed;
                period   <= '0;
                lockup   <= accept_zero;
                timeout  <= 1'b0;
`ifdef LFSR_PERIOD_LOAD_CHK_EN
                load_err <= 1'b0;
`endif
            end
            if (state_q == LOAD) begin
                cnt <= '0;
            end else if (state_q == RUN && cnt != MAX_CNT) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (match) begin
                period <= cnt;
            end
            if (tmo) begin
                period  <= '0;
                timeout <= 1'b1;
            end
`ifdef LFSR_PERIOD_LOAD_CHK_EN
            if (ld_fail) begin
                period   <= '0;
                load_err <= 1'b1;
            end
`endif
        end
    end

    assign lfsr_sel      = (state_q == RUN);
    assign busy          = (state_q == LOAD) || (state_q == RUN);
    assign done          = (state_q == DONE);
    assign lfsr_load_val = seed_reg;

endmodule

// File: tb/tb_lfsr_period_meter.sv
// tb/tb_lfsr_period_meter.sv - table-driven bench for lfsr_period_meter with behavioural Galois LFSRs
module tb_lfsr_period_meter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_a = 1'b0, start_b = 1'b0;
    logic [5:0] seed_a = '0, seed_b = '0;
    logic [5:0] lq_a, lq_b, q_a_in;
    logic       sel_a, sel_b;
    logic [5:0] lv_a, lv_b;
    logic       busy_a, busy_b, done_a, done_b;
    logic [6:0] period_a, period_b;
    logic       lockup_a, lockup_b, timeout_a, timeout_b;
    logic       force_q5 = 1'b0;
`ifdef LFSR_PERIOD_LOAD_CHK_EN
    logic       load_err_a, load_err_b;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    function automatic logic [5:0] gstep(input logic [5:0] s);
        return s[5] ? ({s[4:0], 1'b0} ^ 6'h0B) : {s[4:0], 1'b0};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lq_a <= '0;
            lq_b <= '0;
        end else begin
            lq_a <= sel_a ? gstep(lq_a) : lv_a;
            lq_b <= sel_b ? gstep(lq_b) : lv_b;
        end
    end

    assign q_a_in = force_q5 ? 6'd5 : lq_a;

    lfsr_period_meter #(.WIDTH(6), .MAX_CYCLES(64), .CNT_W(7)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .seed(seed_a), .lfsr_q(q_a_in),
        .lfsr_sel(sel_a), .lfsr_load_val(lv_a), .busy(busy_a), .done(done_a),
        .period(period_a), .lockup(lockup_a),
`ifdef LFSR_PERIOD_LOAD_CHK_EN
        .load_err(load_err_a),
`endif
        .timeout(timeout_a)
    );

    lfsr_period_meter #(.WIDTH(6), .MAX_CYCLES(16), .CNT_W(7)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .seed(seed_b), .lfsr_q(lq_b),
        .lfsr_sel(sel_b), .lfsr_load_val(lv_b), .busy(busy_b), .done(done_b),
        .period(period_b), .lockup(lockup_b),
`ifdef LFSR_PERIOD_LOAD_CHK_EN
        .load_err(load_err_b),
`endif
        .timeout(timeout_b)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Start a measurement; lat counts cycles from the accepting edge to the done pulse (-1 if none).
    task automatic measure(input bit which, input logic [5:0] s, input bit poke,
                           output int lat, output int busy_n, output int lv_bad);
        @(negedge clk);
        if (which) begin start_b = 1'b1; seed_b = s; end
        else       begin start_a = 1'b1; seed_a = s; end
        @(posedge clk);
        lat = -1; busy_n = 0; lv_bad = 0;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (poke && n >= 10 && n <= 12) begin
                start_a = 1'b1; seed_a = 6'd2;
            end else begin
                start_a = 1'b0; start_b = 1'b0;
            end
            if (which ? busy_b : busy_a) begin
                busy_n++;
                if ((which ? lv_b : lv_a) != s) lv_bad++;
            end
            if (which ? done_b : done_a) begin
                lat = n;
                break;
            end
        end
        start_a = 1'b0; start_b = 1'b0;
    endtask

    typedef struct {
        logic [5:0] seed;
        int         exp_period;
        int         exp_lockup;
        int         exp_lat;
        int         exp_busy;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int lat, bn, lvb, seen;
        vecs[0] = '{6'd1,  28, 0, 31, 30};
        vecs[1] = '{6'd0,   0, 1,  1,  0};
        vecs[2] = '{6'd32, 28, 0, 31, 30};
        vecs[3] = '{6'd37, 28, 0, 31, 30};
        vecs[4] = '{6'd63, 14, 0, 17, 16};
        vecs[5] = '{6'd3,  14, 0, 17, 16};

        repeat (3) @(negedge clk);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_sel", sel_a, 0);
        chk("rst_period", period_a, 0);
        chk("rst_flags", {lockup_a, timeout_a}, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            measure(1'b0, vecs[i].seed, 1'b0, lat, bn, lvb);
            chk($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
            chk($sformatf("v%0d_busy_cycles", i), bn, vecs[i].exp_busy);
            chk($sformatf("v%0d_period", i), period_a, vecs[i].exp_period);
            chk($sformatf("v%0d_lockup", i), lockup_a, vecs[i].exp_lockup);
            chk($sformatf("v%0d_timeout", i), timeout_a, 0);
        end

        measure(1'b1, 6'd1, 1'b0, lat, bn, lvb);
        chk("tmo_latency", lat, 19);
        chk("tmo_timeout", timeout_b, 1);
        chk("tmo_period", period_b, 0);
        chk("tmo_busy_cycles", bn, 18);

        measure(1'b0, 6'd1, 1'b1, lat, bn, lvb);
        chk("ign_latency", lat, 31);
        chk("ign_period", period_a, 28);
        chk("ign_load_val_bad", lvb, 0);

        @(negedge clk);
        start_a = 1'b1; seed_a = 6'd1;
        @(posedge clk);
        @(negedge clk);
        start_a = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy_a, 0);
        chk("mid_rst_sel", sel_a, 0);
        chk("mid_rst_load_val", lv_a, 0);
        chk("mid_rst_done", done_a, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done_a || busy_a) seen++;
        end
        chk("mid_rst_no_done", seen, 0);
        measure(1'b0, 6'd1, 1'b0, lat, bn, lvb);
        chk("post_rst_latency", lat, 31);
        chk("post_rst_period", period_a, 28);

`ifdef LFSR_PERIOD_LOAD_CHK_EN
        chk("lchk_clear", load_err_a, 0);
        force_q5 = 1'b1;
        measure(1'b0, 6'd1, 1'b0, lat, bn, lvb);
        force_q5 = 1'b0;
        chk("lchk_latency", lat, 3);
        chk("lchk_load_err", load_err_a, 1);
        chk("lchk_period", period_a, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
